// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_mem_pkg
// Description : Shared types and defaults for the two-port memory arbiter:
//               FSM state encoding, default bus widths and a small helper
//               for one-hot requester selection.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

  localparam int c_ADDR_W = 10;
  localparam int c_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // One-hot code for the requester that is NOT the given one
  function automatic logic [1:0] other_of(input logic owner);
    return owner ? 2'b01 : 2'b10;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_arb_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner selection between requester 0
//               (datapath) and requester 1 (debug loader). A lone requester
//               always wins. On a tie the burst limit forces a hand-over to
//               the requester not served last; otherwise requester 1 wins,
//               or with MEM_ARBITER_RR_EN defined the requester not served
//               last wins (round-robin).
// Config      : MEM_ARBITER_RR_EN
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
  import cpu_mem_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_owner,
  input  logic       i_burst_full,
  output logic [1:0] o_winner
);

  // Priority decision for the current request pair
  always_comb begin
    o_winner = 2'b00;
    case (i_req)
      2'b01: o_winner = 2'b01;
      2'b10: o_winner = 2'b10;
      2'b11: begin
        if (i_burst_full) begin
          o_winner = other_of(i_last_owner);
        end else begin
`ifdef MEM_ARBITER_RR_EN
          o_winner = other_of(i_last_owner);
`else
          o_winner = 2'b10;
`endif
        end
      end
      default: o_winner = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter for a single-port synchronous memory.
//               IDLE -> ACCESS (memory driven one cycle) -> DONE (ack pulse),
//               with a direct DONE -> ACCESS hand-over to the other requester
//               for one access every two cycles. A burst counter caps
//               consecutive grants to one owner while the other waits.
// Config      : MEM_ARBITER_RR_EN selects round-robin tie-breaking; when
//               undefined requester 1 has fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W    = c_ADDR_W,
  parameter int DATA_W    = c_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  output logic              WE,
  input  logic [DATA_W-1:0] readData,
  output logic [1:0]        grant
);

  localparam int                 c_CNT_W     = $clog2(MAX_BURST + 1);
  localparam logic [c_CNT_W-1:0] c_BURST_MAX = c_CNT_W'(MAX_BURST);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          w_req_eff;
  logic [1:0]          w_winner;
  logic                w_start;
  logic                w_burst_full;

  logic [c_CNT_W-1:0]  r_burst_cnt;
  logic                r_last_owner;
  logic [1:0]          r_grant;
  logic                r_we;
  logic                r_we_op;
  logic                r_ack0;
  logic                r_ack1;
  logic [ADDR_W-1:0]   r_address;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  assign w_burst_full = (r_burst_cnt == c_BURST_MAX);

  arb_pick u_arb_pick (
    .i_req        (w_req_eff),
    .i_last_owner (r_last_owner),
    .i_burst_full (w_burst_full),
    .o_winner     (w_winner)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; in DONE the owner's still-asserted request belongs to the
  // access being acknowledged, so only the other requester is considered
  always_comb begin
    w_state_nxt = r_state;
    w_req_eff   = 2'b00;
    case (r_state)
      ST_IDLE: begin
        w_req_eff = {req1, req0};
        if (w_winner != 2'b00) w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_req_eff   = {req1, req0} & ~r_grant;
        w_state_nxt = (w_winner != 2'b00) ? ST_ACCESS : ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_start = (w_state_nxt == ST_ACCESS);

  // Request latching, memory strobes, acks, burst tracking and read capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_burst_cnt  <= '0;
      r_last_owner <= 1'b1;
      r_grant      <= 2'b00;
      r_we         <= 1'b0;
      r_we_op      <= 1'b0;
      r_ack0       <= 1'b0;
      r_ack1       <= 1'b0;
      r_address    <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (r_state == ST_ACCESS) begin
        r_we   <= 1'b0;
        r_ack0 <= r_grant[0];
        r_ack1 <= r_grant[1];
      end
      if (r_state == ST_DONE) begin
        if (r_ack0 && !r_we_op) r_rdata0 <= readData;
        if (r_ack1 && !r_we_op) r_rdata1 <= readData;
        r_grant <= 2'b00;
      end
      if (w_start) begin
        r_grant      <= w_winner;
        r_we         <= w_winner[1] ? we1 : we0;
        r_we_op      <= w_winner[1] ? we1 : we0;
        r_address    <= w_winner[1] ? addr1 : addr0;
        r_wdata      <= w_winner[1] ? wdata1 : wdata0;
        r_last_owner <= w_winner[1];
        if (w_winner[1] != r_last_owner) r_burst_cnt <= c_CNT_ONE;
        else if (!w_burst_full)          r_burst_cnt <= r_burst_cnt + c_CNT_ONE;
      end
    end
  end

  // Reset gates the write strobe immediately so an aborted write never
  // reaches the memory on the reset edge
  assign WE        = r_we & ~reset;
  assign address   = r_address;
  assign writeData = r_wdata;
  assign grant     = r_grant;
  assign ack0      = r_ack0;
  assign ack1      = r_ack1;

  // Memory read data arrives in the ack cycle and is forwarded there;
  // afterwards the captured copy is held
  assign rdata0 = (r_ack0 && !r_we_op) ? readData : r_rdata0;
  assign rdata1 = (r_ack1 && !r_we_op) ? readData : r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed latency,
//               arbitration, burst and reset-abort scenarios followed by
//               randomized traffic from both requesters, scored against a
//               transaction-level memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int MB = 4;
`ifdef MEM_ARBITER_RR_EN
  localparam int RR_MODE = 1;
`else
  localparam int RR_MODE = 0;
`endif

  logic          clk, reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] address;
  logic [DW-1:0] writeData;
  logic          WE;
  logic [DW-1:0] readData;
  logic [1:0]    grant;

  logic          init_mem;
  logic [DW-1:0] mem    [0:1023];
  logic [DW-1:0] shadow [0:1023];
  logic [DW-1:0] prev   [2];
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            checks;
  int            errors;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .address(address), .writeData(writeData), .WE(WE),
    .readData(readData), .grant(grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] init_val(input int i);
    if (i == 5) return 16'h8060;
    return DW'((i * 37) ^ 23130);
  endfunction

  // Synchronous memory: write on WE, read data one cycle after address
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
    end else if (WE) begin
      mem[address] <= writeData;
    end
    readData <= mem[address];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ack_of(input int who);
    return (who == 1) ? ack1 : ack0;
  endfunction

  task automatic set_req(input int who, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (who == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
    else          begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
  endtask

  // Reference model: reads return the latest value written to the word,
  // writes leave the requester's read-data at its last read result
  task automatic push_exp(input int who, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [DW-1:0] e;
    if (w) begin
      shadow[a] = d;
      e = prev[who];
    end else begin
      e = shadow[a];
      prev[who] = e;
    end
    if (who == 0) q0.push_back(e);
    else          q1.push_back(e);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    prev[0] = '0;
    prev[1] = '0;
  endtask

  // Lone request from an idle arbiter; entered and left at posedge+1
  task automatic do_single(input int who, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_req(who, 1, w, a, d);
    push_exp(who, w, a, d);
    @(posedge clk);
    @(negedge clk);
    chk("acc_address", 32'(address), 32'(a));
    chk("acc_we", 32'(WE), 32'(w));
    if (w) chk("acc_wdata", 32'(writeData), 32'(d));
    chk("acc_grant", 32'(grant), (who == 1) ? 32'd2 : 32'd1);
    @(negedge clk);
    chk("ack_timing", 32'(ack_of(who)), 32'd1);
    chk("we_in_done", 32'(WE), 32'd0);
    @(posedge clk); #1;
    set_req(who, 0, 0, '0, '0);
  endtask

  // Both requesters read in the same cycle; exp_first names the winner
  task automatic run_pair(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input int exp_first);
    int t0, t1;
    set_req(0, 1, 0, a0, '0);
    set_req(1, 1, 0, a1, '0);
    push_exp(0, 0, a0, '0);
    push_exp(1, 0, a1, '0);
    @(posedge clk);
    @(negedge clk);
    chk("pair_grant", 32'(grant), (exp_first == 1) ? 32'd2 : 32'd1);
    t0 = -1;
    t1 = -1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (t0 >= 0) req0 = 1'b0;
      if (t1 >= 0) req1 = 1'b0;
      @(negedge clk);
      if (ack0 && t0 < 0) t0 = c;
      if (ack1 && t1 < 0) t1 = c;
    end
    chk("pair_first_ack", 32'((exp_first == 1) ? t1 : t0), 32'd1);
    chk("pair_second_ack", 32'((exp_first == 1) ? t0 : t1), 32'd3);
    @(posedge clk); #1;
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  // Random traffic for one requester; each side owns one address parity
  task automatic rand_driver(input int who, input int n);
    for (int k = 0; k < n; k++) begin
      int            gap;
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic          got;
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin @(posedge clk); #1; end
      w    = 1'($urandom_range(0, 1));
      a    = AW'($urandom_range(0, 1023));
      a[0] = (who == 1);
      d    = DW'($urandom);
      set_req(who, 1, w, a, d);
      push_exp(who, w, a, d);
      got = 1'b0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (ack_of(who)) begin
          got = 1'b1;
          break;
        end
      end
      chk((who == 1) ? "latency1" : "latency0", 32'(got), 32'd1);
      @(posedge clk); #1;
      set_req(who, 0, 0, '0, '0);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    init_mem = 1'b1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    prev[0] = '0;
    prev[1] = '0;
    for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);

    // Monitor: score every ack against the model and watch bus invariants
    fork
      forever begin
        @(negedge clk);
        if (ack0 || ack1) chk("ack_exclusive", 32'(ack0 & ack1), 32'd0);
        if (ack0 === 1'b1) begin
          if (q0.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack0 actual=1 expected=0 t=%0t", $time);
          end else chk("rdata0", 32'(rdata0), 32'(q0.pop_front()));
        end
        if (ack1 === 1'b1) begin
          if (q1.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack1 actual=1 expected=0 t=%0t", $time);
          end else chk("rdata1", 32'(rdata1), 32'(q1.pop_front()));
        end
        if (WE === 1'b1) chk("we_only_in_access", 32'(grant != 2'b00 && !ack0 && !ack1), 32'd1);
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", 32'(WE), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_wdata", 32'(writeData), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    @(posedge clk); #1;
    reset    = 1'b0;
    init_mem = 1'b0;

    // Single read, single write, read-back, write holding rdata
    do_single(0, 1'b0, 10'h005, 16'h0000);
    do_single(1, 1'b1, 10'h3FF, 16'hB00F);
    do_single(0, 1'b0, 10'h3FF, 16'h0000);
    chk("rdata0_hold", 32'(rdata0), 32'h0000B00F);
    do_single(1, 1'b0, 10'h005, 16'h0000);
    do_single(1, 1'b1, 10'h006, 16'h1357);
    chk("rdata1_hold_after_write", 32'(rdata1), 32'h00008060);

    // Simultaneous requests straight from reset
    apply_reset();
    run_pair(10'h010, 10'h011, (RR_MODE != 0) ? 0 : 1);

    // Three grants to requester 1: burst not yet full
    apply_reset();
    repeat (3) do_single(1, 1'b0, 10'h021, 16'h0000);
    run_pair(10'h030, 10'h031, (RR_MODE != 0) ? 0 : 1);

    // Four grants to requester 1: burst full, requester 0 must win
    apply_reset();
    repeat (4) do_single(1, 1'b0, 10'h021, 16'h0000);
    run_pair(10'h032, 10'h033, 0);

    // Reset during the ACCESS cycle of a write aborts it
    set_req(1, 1, 1'b1, 10'h020, 16'h1234);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_abort_we_gate", 32'(WE), 32'd0);
    @(posedge clk); #1;
    set_req(1, 0, 0, '0, '0);
    @(negedge clk);
    chk("rst_abort_we", 32'(WE), 32'd0);
    chk("rst_abort_grant", 32'(grant), 32'd0);
    chk("rst_abort_ack1", 32'(ack1), 32'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    prev[0] = '0;
    prev[1] = '0;
    do_single(0, 1'b0, 10'h020, 16'h0000);

    // Randomized concurrent traffic
    fork
      rand_driver(0, 150);
      rand_driver(1, 150);
    join
    repeat (4) @(posedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
